// File: rtl/hazard_unit_mc.sv
// Multi-cycle hazard controller for the 5-stage RV32I pipeline: M/W forwarding, branch flush,
// load-use stall of configurable length, mul/div and data-memory wait stalls, stall-cycle counter.
//
// state    | meaning
// RUN      | no multi-cycle hazard in progress
// LOADWAIT | load-use stall still has cnt_q cycles to run
// MULDIV   | waiting for the mul/div unit to finish
// MEMWAIT  | waiting for data memory; frz_q marks a load-use stall parked underneath
module hazard_unit_mc #(
  parameter int ADDRESS_WIDTH   = 5,
  parameter int FORWARD_WIDTH   = 2,
  parameter int LOAD_USE_CYCLES = 1,
  parameter int CNT_WIDTH       = 3,
  parameter int PERF_WIDTH      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDRESS_WIDTH-1:0] Rs1D,
  input  logic [ADDRESS_WIDTH-1:0] Rs2D,
  input  logic [ADDRESS_WIDTH-1:0] Rs1E,
  input  logic [ADDRESS_WIDTH-1:0] Rs2E,
  input  logic [ADDRESS_WIDTH-1:0] RdE,
  input  logic                     ResultSrcE0,
  input  logic                     PCSrcE,
  input  logic                     MulDivE,
  input  logic                     MulDivDoneE,
  input  logic [ADDRESS_WIDTH-1:0] RdM,
  input  logic                     RegWriteM,
  input  logic                     DMemReqM,
  input  logic                     DMemReadyM,
  input  logic [ADDRESS_WIDTH-1:0] RdW,
  input  logic                     RegWriteW,
  output logic                     StallF,
  output logic                     StallD,
  output logic                     StallE,
  output logic                     StallM,
  output logic                     FlushD,
  output logic                     FlushE,
  output logic                     FlushM,
  output logic                     FlushW,
  output logic [FORWARD_WIDTH-1:0] ForwardAE,
  output logic [FORWARD_WIDTH-1:0] ForwardBE,
  output logic [1:0]               HzState,
  output logic [PERF_WIDTH-1:0]    StallCount
);

  localparam logic [1:0] S_RUN      = 2'b00;
  localparam logic [1:0] S_LOADWAIT = 2'b01;
  localparam logic [1:0] S_MULDIV   = 2'b10;
  localparam logic [1:0] S_MEMWAIT  = 2'b11;

  logic [1:0]            state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  frz_q, frz_d;
  logic [PERF_WIDTH-1:0] perf_q, perf_d;

  logic memstall, mdstall, branch, lwstall, lw_pend;

  always_comb begin
    ForwardAE = FORWARD_WIDTH'(2'b00);
    if (RegWriteM && RdM != '0 && RdM == Rs1E)      ForwardAE = FORWARD_WIDTH'(2'b10);
    else if (RegWriteW && RdW != '0 && RdW == Rs1E) ForwardAE = FORWARD_WIDTH'(2'b01);
  end

  always_comb begin
    ForwardBE = FORWARD_WIDTH'(2'b00);
    if (RegWriteM && RdM != '0 && RdM == Rs2E)      ForwardBE = FORWARD_WIDTH'(2'b10);
    else if (RegWriteW && RdW != '0 && RdW == Rs2E) ForwardBE = FORWARD_WIDTH'(2'b01);
  end

  assign memstall = DMemReqM & ~DMemReadyM;
  assign mdstall  = MulDivE & ~MulDivDoneE;
  assign branch   = PCSrcE & ~memstall & ~mdstall;
  assign lwstall  = ResultSrcE0 & (RdE != '0) & ((RdE == Rs1D) | (RdE == Rs2D))
                    & ~branch & ~memstall & ~mdstall;
  // A load-use stall is owed both in LOADWAIT and while parked under a memory wait.
  assign lw_pend  = (state_q == S_LOADWAIT) | ((state_q == S_MEMWAIT) & frz_q);

  always_comb begin
    StallF = 1'b0; StallD = 1'b0; StallE = 1'b0; StallM = 1'b0;
    FlushD = 1'b0; FlushE = 1'b0; FlushM = 1'b0; FlushW = 1'b0;
    if (memstall) begin
      StallF = 1'b1; StallD = 1'b1; StallE = 1'b1; StallM = 1'b1; FlushW = 1'b1;
    end else if (mdstall) begin
      StallF = 1'b1; StallD = 1'b1; StallE = 1'b1; FlushM = 1'b1;
    end else if (branch) begin
      FlushD = 1'b1; FlushE = 1'b1;
    end else if (lwstall || lw_pend) begin
      StallF = 1'b1; StallD = 1'b1; FlushE = 1'b1;
    end
  end

  always_comb begin
    state_d = S_RUN;
    cnt_d   = cnt_q;
    frz_d   = 1'b0;
    if (memstall) begin
      state_d = S_MEMWAIT;
      frz_d   = lw_pend;
    end else if (lw_pend) begin
      if (cnt_q == CNT_WIDTH'(1)) begin
        state_d = S_RUN;
        cnt_d   = '0;
      end else begin
        state_d = S_LOADWAIT;
        cnt_d   = cnt_q - CNT_WIDTH'(1);
      end
    end else if (mdstall) begin
      state_d = S_MULDIV;
    end else if (lwstall && LOAD_USE_CYCLES > 1) begin
      state_d = S_LOADWAIT;
      cnt_d   = CNT_WIDTH'(LOAD_USE_CYCLES - 1);
    end
  end

  assign perf_d = (StallF && perf_q != '1) ? perf_q + PERF_WIDTH'(1) : perf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      frz_q   <= 1'b0;
      perf_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frz_q   <= frz_d;
      perf_q  <= perf_d;
    end
  end

  assign HzState    = state_q;
  assign StallCount = perf_q;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc (LOAD_USE_CYCLES=3): directed scenarios plus randomized traffic
// checked against a model that tracks owed load-use stall cycles as a plain integer.
module tb_hazard_unit_mc;
  localparam int L = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic ResultSrcE0, PCSrcE, MulDivE, MulDivDoneE, RegWriteM, DMemReqM, DMemReadyM, RegWriteW;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW;
  logic [1:0] ForwardAE, ForwardBE, HzState;
  logic [15:0] StallCount;
  logic [7:0] ctl;

  int n_cmp = 0;
  int n_bad = 0;

  // model: mode 0 RUN, 1 LOADWAIT, 2 MULDIV, 3 MEMWAIT; m_left = load-use stall cycles still owed
  int m_mode, m_left, m_cnt;

  always #5 clk = ~clk;

  hazard_unit_mc #(.LOAD_USE_CYCLES(L)) dut (
    .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .MulDivE(MulDivE), .MulDivDoneE(MulDivDoneE),
    .RdM(RdM), .RegWriteM(RegWriteM), .DMemReqM(DMemReqM), .DMemReadyM(DMemReadyM),
    .RdW(RdW), .RegWriteW(RegWriteW), .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .StallM(StallM), .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .HzState(HzState), .StallCount(StallCount));

  assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW};

  function automatic logic [3:0] flags();
    logic mem, md, br, lw;
    mem = DMemReqM && !DMemReadyM;
    md  = MulDivE && !MulDivDoneE;
    br  = PCSrcE && !mem && !md;
    lw  = ResultSrcE0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D) && !br && !mem && !md;
    return {mem, md, br, lw};
  endfunction

  function automatic logic [7:0] exp_ctl();
    logic [3:0] f;
    f = flags();
    if (f[3]) return 8'hF1;
    if (f[2]) return 8'hE2;
    if (f[1]) return 8'h0C;
    if (f[0] || m_left > 0) return 8'hC4;
    return 8'h00;
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 0; m_left <= 0; m_cnt <= 0;
    end else begin
      logic [3:0] f;
      f = flags();
      if (exp_ctl() >= 8'h80 && m_cnt < 65535) m_cnt <= m_cnt + 1;
      if (f[3]) m_mode <= 3;
      else if (m_left > 0) begin
        m_left <= m_left - 1;
        m_mode <= (m_left > 1) ? 1 : 0;
      end else if (f[2]) m_mode <= 2;
      else if (f[0] && L > 1) begin
        m_left <= L - 1;
        m_mode <= 1;
      end else m_mode <= 0;
    end
  end

  task automatic idle();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE0 = 0; PCSrcE = 0; MulDivE = 0; MulDivDoneE = 0;
    RegWriteM = 0; DMemReqM = 0; DMemReadyM = 0; RegWriteW = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0; #2; rst_n = 1;
    tick();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0; #2;
    n_cmp++; if (HzState !== 2'b00) begin n_bad++; $display("FAIL reset_state got %b want 00", HzState); end
    n_cmp++; if (StallCount !== 16'h0) begin n_bad++; $display("FAIL reset_count got %h want 0000", StallCount); end
    n_cmp++; if (ctl !== 8'h00) begin n_bad++; $display("FAIL reset_ctl got %h want 00", ctl); end
    rst_n = 1;
    tick();
  endtask

  task automatic test_forward();
    idle();
    RdM = 5; RdW = 5; RegWriteM = 1; RegWriteW = 1; Rs1E = 5; Rs2E = 5; #1;
    n_cmp++; if (ForwardAE !== 2'b10) begin n_bad++; $display("FAIL fwdA_M got %b want 10", ForwardAE); end
    n_cmp++; if (ForwardBE !== 2'b10) begin n_bad++; $display("FAIL fwdB_M got %b want 10", ForwardBE); end
    RegWriteM = 0; #1;
    n_cmp++; if (ForwardAE !== 2'b01) begin n_bad++; $display("FAIL fwdA_W got %b want 01", ForwardAE); end
    Rs1E = 0; #1;
    n_cmp++; if (ForwardAE !== 2'b00) begin n_bad++; $display("FAIL fwdA_x0 got %b want 00", ForwardAE); end
    RegWriteM = 1; RdM = 0; Rs2E = 0; RdW = 0; #1;
    n_cmp++; if (ForwardBE !== 2'b00) begin n_bad++; $display("FAIL fwdB_rd0 got %b want 00", ForwardBE); end
    idle();
  endtask

  task automatic test_load_use();
    do_reset();
    ResultSrcE0 = 1; RdE = 7; Rs2D = 7; Rs1D = 1;
    for (int i = 0; i < L; i++) begin
      @(negedge clk);
      n_cmp++; if (ctl !== 8'hC4) begin n_bad++; $display("FAIL lu_cyc%0d got %h want c4", i, ctl); end
      tick();
      idle();
    end
    @(negedge clk);
    n_cmp++; if (ctl !== 8'h00) begin n_bad++; $display("FAIL lu_end got %h want 00", ctl); end
    n_cmp++; if (HzState !== 2'b00) begin n_bad++; $display("FAIL lu_state got %b want 00", HzState); end
    n_cmp++; if (StallCount !== 16'd3) begin n_bad++; $display("FAIL lu_count got %0d want 3", StallCount); end
    tick();
  endtask

  task automatic test_branch_lw();
    do_reset();
    ResultSrcE0 = 1; RdE = 7; Rs1D = 7; PCSrcE = 1;
    @(negedge clk);
    n_cmp++; if (ctl !== 8'h0C) begin n_bad++; $display("FAIL br_ctl got %h want 0c", ctl); end
    tick();
    idle();
    @(negedge clk);
    n_cmp++; if (HzState !== 2'b00) begin n_bad++; $display("FAIL br_state got %b want 00", HzState); end
    n_cmp++; if (ctl !== 8'h00) begin n_bad++; $display("FAIL br_after got %h want 00", ctl); end
    tick();
  endtask

  task automatic test_muldiv();
    do_reset();
    MulDivE = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++; if (ctl !== 8'hE2) begin n_bad++; $display("FAIL md_cyc%0d got %h want e2", i, ctl); end
      tick();
    end
    MulDivDoneE = 1;
    @(negedge clk);
    n_cmp++; if (ctl !== 8'h00) begin n_bad++; $display("FAIL md_done got %h want 00", ctl); end
    n_cmp++; if (HzState !== 2'b10) begin n_bad++; $display("FAIL md_state got %b want 10", HzState); end
    tick();
    idle();
    @(negedge clk);
    n_cmp++; if (HzState !== 2'b00) begin n_bad++; $display("FAIL md_exit got %b want 00", HzState); end
    tick();
  endtask

  task automatic test_mem_in_loadwait();
    logic [7:0]  want_c [6] = '{8'hC4, 8'hF1, 8'hF1, 8'hC4, 8'hC4, 8'h00};
    logic [1:0]  want_s [6] = '{2'b00, 2'b01, 2'b11, 2'b11, 2'b01, 2'b00};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      idle();
      if (i == 0) begin ResultSrcE0 = 1; RdE = 7; Rs2D = 7; end
      if (i == 1 || i == 2 || i == 3) DMemReqM = 1;
      if (i == 3) DMemReadyM = 1;
      @(negedge clk);
      n_cmp++; if (ctl !== want_c[i]) begin n_bad++; $display("FAIL mw_ctl%0d got %h want %h", i, ctl, want_c[i]); end
      n_cmp++; if (HzState !== want_s[i]) begin n_bad++; $display("FAIL mw_st%0d got %b want %b", i, HzState, want_s[i]); end
      tick();
    end
    n_cmp++; if (StallCount !== 16'd5) begin n_bad++; $display("FAIL mw_count got %0d want 5", StallCount); end
  endtask

  task automatic test_async_reset();
    do_reset();
    MulDivE = 1;
    repeat (3) tick();
    @(negedge clk);
    n_cmp++; if (HzState !== 2'b10) begin n_bad++; $display("FAIL ar_pre got %b want 10", HzState); end
    rst_n = 0; MulDivE = 0; #1;
    n_cmp++; if (ctl !== 8'h00) begin n_bad++; $display("FAIL ar_ctl got %h want 00", ctl); end
    n_cmp++; if (HzState !== 2'b00) begin n_bad++; $display("FAIL ar_state got %b want 00", HzState); end
    n_cmp++; if (StallCount !== 16'h0) begin n_bad++; $display("FAIL ar_count got %h want 0000", StallCount); end
    #1; rst_n = 1;
    tick();
  endtask

  task automatic test_saturate();
    do_reset();
    MulDivE = 1;
    repeat (65535) tick();
    @(negedge clk);
    n_cmp++; if (StallCount !== 16'hFFFF) begin n_bad++; $display("FAIL sat_reach got %h want ffff", StallCount); end
    repeat (4) tick();
    @(negedge clk);
    n_cmp++; if (StallCount !== 16'hFFFF) begin n_bad++; $display("FAIL sat_hold got %h want ffff", StallCount); end
    idle();
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE = 5'($urandom_range(0, 3)); RdM = 5'($urandom_range(0, 3)); RdW = 5'($urandom_range(0, 3));
      RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
      ResultSrcE0 = ($urandom_range(0, 2) == 0);
      PCSrcE = ($urandom_range(0, 7) == 0);
      MulDivE = ($urandom_range(0, 4) == 0); MulDivDoneE = 1'($urandom_range(0, 1));
      DMemReqM = ($urandom_range(0, 3) == 0); DMemReadyM = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_cmp++; if (ctl !== exp_ctl()) begin n_bad++; $display("FAIL rnd_ctl@%0d got %h want %h", i, ctl, exp_ctl()); end
      n_cmp++; if (ForwardAE !== exp_fwd(Rs1E)) begin n_bad++; $display("FAIL rnd_fwdA@%0d got %b want %b", i, ForwardAE, exp_fwd(Rs1E)); end
      n_cmp++; if (ForwardBE !== exp_fwd(Rs2E)) begin n_bad++; $display("FAIL rnd_fwdB@%0d got %b want %b", i, ForwardBE, exp_fwd(Rs2E)); end
      n_cmp++; if (HzState !== 2'(m_mode)) begin n_bad++; $display("FAIL rnd_state@%0d got %0d want %0d", i, HzState, m_mode); end
      n_cmp++; if (StallCount !== 16'(m_cnt)) begin n_bad++; $display("FAIL rnd_count@%0d got %0d want %0d", i, StallCount, m_cnt); end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_forward();
    test_load_use();
    test_branch_lw();
    test_muldiv();
    test_mem_in_loadwait();
    test_random();
    test_async_reset();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
